polar_to_complex: RTL and testbench

//  Iterative CORDIC rotator: converts a (magnitude, phase) sample into signed I/Q.

---
 rtl/polar_to_complex_if.sv | 26 ++
 rtl/polar_to_complex.sv | 167 ++++++++++++++++
 tb/tb_polar_to_complex.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/polar_to_complex_if.sv
// Sample handshake bundle for polar_to_complex: magnitude/phase in, I/Q out.
// The master drives the sample side; the slave is the rotator.
interface polar_to_complex_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16
);
  logic                          enable;
  logic        [DATA_WIDTH-1:0]  mag;
  logic signed [PHASE_WIDTH-1:0] phase;
  logic                          input_strobe;
  logic                          ready;
  logic signed [DATA_WIDTH-1:0]  i;
  logic signed [DATA_WIDTH-1:0]  q;
  logic                          output_strobe;
  logic                          overrun;

  modport master (
    output enable, mag, phase, input_strobe,
    input  ready, i, q, output_strobe, overrun
  );

  modport slave (
    input  enable, mag, phase, input_strobe,
    output ready, i, q, output_strobe, overrun
  );
endinterface

// File: rtl/polar_to_complex.sv
// Iterative CORDIC rotator: (magnitude, phase) -> saturated signed I/Q, one sample in flight.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that removes the CORDIC gain (+1 cycle latency).
module polar_to_complex #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int ITERATIONS  = 14
) (
  input logic               clock,
  input logic               reset,
  polar_to_complex_if.slave bus
);
  localparam int XW = DATA_WIDTH + 3;
  localparam int CW = $clog2(ITERATIONS);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);
  localparam logic [63:0] PI_Q61 = 64'h6487ED5110B4611A;
  localparam logic signed [XW-1:0] SAT_MAX = {4'b0000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {4'b1111, {(DATA_WIDTH-1){1'b0}}};

  // atan(2^-k) in units of pi/2^(PHASE_WIDTH-1), rounded; the arctangent series runs in Q61.
  function automatic logic [ITERATIONS*PHASE_WIDTH-1:0] build_atan_tab();
    logic [ITERATIONS*PHASE_WIDTH-1:0] tab;
    logic [127:0] acc;
    logic [127:0] term;
    logic [127:0] ent;
    tab = '0;
    for (int k = 0; k < ITERATIONS; k++) begin
      if (k == 0) begin
        ent = 128'(1) << (PHASE_WIDTH - 3);
      end else begin
        acc = '0;
        for (int n = 0; k * (2 * n + 1) < 62; n++) begin
          term = (128'(1) << (61 - k * (2 * n + 1))) / 128'(2 * n + 1);
          if (n % 2 == 0) acc = acc + term;
          else            acc = acc - term;
        end
        ent = ((acc << PHASE_WIDTH) + 128'(PI_Q61)) / (128'(PI_Q61) << 1);
      end
      tab[k*PHASE_WIDTH +: PHASE_WIDTH] = PHASE_WIDTH'(ent);
    end
    return tab;
  endfunction

  localparam logic [ITERATIONS*PHASE_WIDTH-1:0] ATAN_TAB = build_atan_tab();

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] c;
    if (v > SAT_MAX)      c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else                  c = v;
    return DATA_WIDTH'(c);
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // 1/K ~= 0.607178 as a shift-add sum, truncating at each term.
  function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 12);
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_GAIN, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_iter;
  logic signed [XW-1:0]    r_x, r_y;
  logic signed [PHASE_WIDTH-1:0] r_z;
  logic signed [DATA_WIDTH-1:0]  r_i, r_q;
  logic                    r_overrun;

  logic                    w_flip;
  logic signed [XW-1:0]    w_mag_ext;
  logic signed [XW-1:0]    w_x0;
  logic signed [PHASE_WIDTH-1:0] w_z0;
  logic signed [XW-1:0]    w_xs, w_ys;
  logic signed [PHASE_WIDTH-1:0] w_atan;
  logic signed [XW-1:0]    w_x_rot, w_y_rot;
  logic signed [PHASE_WIDTH-1:0] w_z_rot;
  logic signed [DATA_WIDTH-1:0]  w_i_sat, w_q_sat;
  logic                    w_done;

  // Capture: fold phases outside [-pi/2, pi/2) into range by a pi rotation (negate x, flip MSB of z).
  assign w_flip    = bus.phase[PHASE_WIDTH-1] ^ bus.phase[PHASE_WIDTH-2];
  assign w_mag_ext = $signed({3'b000, bus.mag});
  assign w_x0      = w_flip ? -w_mag_ext : w_mag_ext;
  assign w_z0      = w_flip ? {~bus.phase[PHASE_WIDTH-1], bus.phase[PHASE_WIDTH-2:0]} : bus.phase;

  // Rotate: one micro-rotation, direction from the sign of the residual angle.
  assign w_xs    = r_x >>> r_iter;
  assign w_ys    = r_y >>> r_iter;
  assign w_atan  = ATAN_TAB[int'(r_iter)*PHASE_WIDTH +: PHASE_WIDTH];
  assign w_x_rot = r_z[PHASE_WIDTH-1] ? r_x + w_ys   : r_x - w_ys;
  assign w_y_rot = r_z[PHASE_WIDTH-1] ? r_y - w_xs   : r_y + w_xs;
  assign w_z_rot = r_z[PHASE_WIDTH-1] ? r_z + w_atan : r_z - w_atan;

  assign w_i_sat = saturate(r_x);
  assign w_q_sat = saturate(r_y);

  always_ff @(posedge clock) begin
    if (reset)           r_state <= S_IDLE;
    else if (bus.enable) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.input_strobe) w_next = S_ROTATE;
      S_ROTATE: if (r_iter == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
        w_next = S_GAIN;
`else
        w_next = S_DONE;
`endif
      end
      S_GAIN:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_iter    <= '0;
      r_i       <= '0;
      r_q       <= '0;
      r_overrun <= 1'b0;
    end else if (bus.enable) begin
      r_iter <= (r_state == S_ROTATE && r_iter != LAST) ? r_iter + 1'b1 : '0;
      if (r_state == S_DONE) begin
        r_i <= w_i_sat;
        r_q <= w_q_sat;
      end
      if (bus.input_strobe && r_state != S_IDLE) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.enable) begin
      case (r_state)
        S_IDLE: if (bus.input_strobe) begin
          r_x <= w_x0;
          r_y <= '0;
          r_z <= w_z0;
        end
        S_ROTATE: begin
          r_x <= w_x_rot;
          r_y <= w_y_rot;
          r_z <= w_z_rot;
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_GAIN: begin
          r_x <= gain_comp(r_x);
          r_y <= gain_comp(r_y);
        end
`endif
        default: ;
      endcase
    end
  end

  // Done: the new result is presented in the same cycle as its strobe, then held in r_i/r_q.
  assign w_done            = (r_state == S_DONE) && bus.enable;
  assign bus.ready         = (r_state == S_IDLE);
  assign bus.output_strobe = w_done;
  assign bus.i             = w_done ? w_i_sat : r_i;
  assign bus.q             = w_done ? w_q_sat : r_q;
  assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_polar_to_complex.sv
// Bench for polar_to_complex: directed checks of the documented cases plus randomized traffic
// scored every cycle against a behavioural CORDIC model.
`timescale 1ns/1ps
module tb_polar_to_complex;
  localparam int DW = 16;
  localparam int PW = 16;
  localparam int IT = 14;
  localparam int WIN = 48;
  localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT  = IT + 2;
  localparam real GAIN = 1.6467602581 * 0.607177734375;
  localparam int  TOL  = 3;
`else
  localparam int  LAT  = IT + 1;
  localparam real GAIN = 1.6467602581;
  localparam int  TOL  = 6;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  polar_to_complex_if #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW)) bus ();
  polar_to_complex #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ITERATIONS(IT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int atan_tab [IT];

  typedef struct { int i; int q; int en_at; } exp_t;
  exp_t sb[$];
  int   exp_i = 0;
  int   exp_q = 0;
  bit   exp_ovr = 1'b0;
  int   en_cyc = 0;
  bit   started = 1'b0;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void check_near(string name, int act, int req, int tol);
    n_checks++;
    if (act < req - tol || act > req + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +-%0d", name, act, req, tol);
    end
  endfunction

  function automatic int sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference: fold into the right half-plane, run the CORDIC recurrence, optionally scale, clamp.
  function automatic void model(input int m, input int ph, output int ri, output int rq);
    int p, z;
    longint x, y, xn;
    p = ph;
    if (p >= 32768) p -= 65536;
    if (p >= 16384 || p < -16384) begin
      x = -longint'(m);
      z = (p >= 0) ? p - 32768 : p + 32768;
    end else begin
      x = longint'(m);
      z = p;
    end
    y = 0;
    for (int k = 0; k < IT; k++) begin
      if (z >= 0) begin
        xn = x - (y >>> k); y = y + (x >>> k); z = z - atan_tab[k];
      end else begin
        xn = x + (y >>> k); y = y - (x >>> k); z = z + atan_tab[k];
      end
      x = xn;
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9) - (x >>> 12);
    y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9) - (y >>> 12);
`endif
    ri = sat16(x);
    rq = sat16(y);
  endfunction

  function automatic int ideal(int m, int ph, bit use_sin);
    real a;
    int p;
    p = ph;
    if (p >= 32768) p -= 65536;
    a = real'(p) * PI / 32768.0;
    return $rtoi($floor(GAIN * real'(m) * (use_sin ? $sin(a) : $cos(a)) + 0.5));
  endfunction

  always @(negedge clock) begin : monitor
    exp_t e;
    int   mi, mq;
    bit   idle;
    if (started) begin
      idle = (sb.size() == 0);
      check("ready", int'(bus.ready), int'(idle));
      check("overrun", int'(bus.overrun), int'(exp_ovr));
      check("strobe_gated", int'(bus.output_strobe && !bus.enable), 0);
      if (bus.output_strobe) begin
        check("strobe_pending", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("i", int'(bus.i), e.i);
          check("q", int'(bus.q), e.q);
          check("latency", en_cyc - e.en_at, LAT);
          exp_i = e.i;
          exp_q = e.q;
        end
      end else begin
        check("i_held", int'(bus.i), exp_i);
        check("q_held", int'(bus.q), exp_q);
      end
      if (reset) begin
        sb.delete();
        exp_ovr = 1'b0;
        exp_i = 0;
        exp_q = 0;
      end else if (bus.enable && bus.input_strobe) begin
        if (idle) begin
          model(int'(bus.mag), int'(bus.phase), mi, mq);
          sb.push_back('{i: mi, q: mq, en_at: en_cyc});
        end else begin
          exp_ovr = 1'b1;
        end
      end
      if (bus.enable) en_cyc++;
    end
  end

  // One sample at cycle 0; optional enable stall, second strobe, or reset at given cycles.
  task automatic run(input int m, input int ph, input int stall_at, input int stall_len,
                     input int extra_at, input int reset_at,
                     output int ri, output int rq, output int cyc, output int nstb);
    @(posedge clock); #1;
    bus.mag = 16'(m);
    bus.phase = 16'(ph);
    bus.input_strobe = 1'b1;
    bus.enable = 1'b1;
    nstb = 0; cyc = -1; ri = 0; rq = 0;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clock);
      if (bus.output_strobe) begin
        if (nstb == 0) begin
          ri = int'(bus.i); rq = int'(bus.q); cyc = c;
        end
        nstb++;
      end
      @(posedge clock); #1;
      bus.input_strobe = (c + 1 == extra_at);
      if (c + 1 == extra_at) begin
        bus.mag = 16'h1234; bus.phase = 16'h1111;
      end
      bus.enable = !(stall_at >= 0 && c + 1 >= stall_at && c + 1 < stall_at + stall_len);
      reset = (c + 1 == reset_at);
    end
  endtask

  initial begin
    int ri, rq, cyc, nstb, mi, mq, sel;
    int ph_list [4];
    bus.enable = 1'b1;
    bus.input_strobe = 1'b0;
    bus.mag = '0;
    bus.phase = '0;
    for (int k = 0; k < IT; k++)
      atan_tab[k] = $rtoi($floor($atan(2.0 ** (-k)) * 32768.0 / PI + 0.5));

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    started = 1'b1;
    @(negedge clock);
    check("rst_ready", int'(bus.ready), 1);
    check("rst_i", int'(bus.i), 0);
    check("rst_q", int'(bus.q), 0);
    check("rst_ostb", int'(bus.output_strobe), 0);
    check("rst_ovr", int'(bus.overrun), 0);

    check("atan0", atan_tab[0], 8192);
    check("atan1", atan_tab[1], 4836);
    check("atan7", atan_tab[7], 81);
    check("atan13", atan_tab[13], 1);
    model(10000, 0, mi, mq);
`ifdef CORDIC_GAIN_COMP_EN
    check("model_i0", mi, 10000);
    check("model_q0", mq, 0);
`else
    check("model_i0", mi, 16470);
    check("model_q0", mq, 1);
`endif
    model(0, 16'h5A5A, mi, mq);
    check("model_zero_i", mi, 0);
    check("model_zero_q", mq, 0);

    run(10000, 0, -1, 0, -1, -1, ri, rq, cyc, nstb);
    check("p0_count", nstb, 1);
    check("p0_cycle", cyc, LAT);
    check_near("p0_i", ri, ideal(10000, 0, 0), 3);
    check_near("p0_q", rq, ideal(10000, 0, 1), 3);

    ph_list = '{16'h4000, 16'h8000, 16'h2000, 16'hC000};
    foreach (ph_list[n]) begin
      run(10000, ph_list[n], -1, 0, -1, -1, ri, rq, cyc, nstb);
      check("ph_count", nstb, 1);
      check_near("ph_i", ri, ideal(10000, ph_list[n], 0), TOL);
      check_near("ph_q", rq, ideal(10000, ph_list[n], 1), TOL);
    end

    run(16'hFFFF, 0, -1, 0, -1, -1, ri, rq, cyc, nstb);
    check("sat_i", ri, 32767);
    run(0, 16'h3A7C, -1, 0, -1, -1, ri, rq, cyc, nstb);
    check("zero_i", ri, 0);
    check("zero_q", rq, 0);

    run(7000, 16'h1800, -1, 0, 3, -1, ri, rq, cyc, nstb);
    check("ovr_count", nstb, 1);
    check("ovr_cycle", cyc, LAT);
    check("ovr_flag", int'(bus.overrun), 1);

    model(9000, 16'hE123, mi, mq);
    run(9000, 16'hE123, 6, 5, -1, -1, ri, rq, cyc, nstb);
    check("stall_cycle", cyc, LAT + 5);
    check("stall_i", ri, mi);
    check("stall_q", rq, mq);

    run(12000, 16'h0C00, -1, 0, -1, 6, ri, rq, cyc, nstb);
    check("rst_mid_count", nstb, 0);
    @(negedge clock);
    check("rst_mid_ready", int'(bus.ready), 1);
    check("rst_mid_i", int'(bus.i), 0);
    check("rst_mid_q", int'(bus.q), 0);
    check("rst_mid_ovr", int'(bus.overrun), 0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.input_strobe = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 499) == 0);
      sel = $urandom_range(0, 7);
      bus.mag = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      bus.phase = 16'($urandom);
    end
    @(posedge clock); #1;
    bus.enable = 1'b1;
    bus.input_strobe = 1'b0;
    reset = 1'b0;
    repeat (LAT + 4) @(posedge clock);
    @(negedge clock);
    check("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
